// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// ex_muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit for the EX stage. It takes decoded operands
// and the mul/div control field from the ID/EX register. It produces a
// 2*WIDTH-bit product, or a quotient/remainder pair, in the architectural
// HI/LO registers. While an operation is in flight, busy stays high so that
// hazard logic stalls the front end.
//
// Multiply : shift-add. The multiplier is consumed LSB first and the
//            multiplicand is shifted left into a 2*WIDTH-bit accumulator.
// Divide   : restoring division on a {rem, quot} register pair.
// Signed ops run on operand magnitudes. A single FIX state then applies the
// sign correction and writes HI/LO.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - a multiply leaves CALC as soon as no multiplier
//                         bits remain. The result is identical; only the
//                         latency changes.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   launch request, sampled only in IDLE
//   op[1:0]      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opa          in   multiplicand / dividend (rs)
//   opb          in   multiplier / divisor (rt)
//   flush        in   synchronous abort of an in-flight operation
//   busy         out  operation in progress (stall request)
//   done         out  one-cycle pulse: HI/LO were written on this edge
//   div_by_zero  out  qualifies done: divide with opb = 0
//   hi           out  product upper half or remainder
//   lo           out  product lower half or quotient
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              W2   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic             sign_a;
    logic             sign_b;
    logic             dz_q;
    logic [CNT_W-1:0] cnt;
    // In a multiply, mcand holds the left-shifting multiplicand. In a divide,
    // its low half keeps the dividend magnitude, which the divide-by-zero
    // result needs.
    logic [W2-1:0]    mcand;
    // In a multiply, mplier holds the right-shifting multiplier. In a divide,
    // it holds the divisor magnitude.
    logic [WIDTH-1:0] mplier;
    // In a multiply, acc is the product. In a divide, it is {rem, quot}.
    logic [W2-1:0]    acc;

    // ------------------------------------------------------------------
    // Operand magnitudes at launch
    // ------------------------------------------------------------------
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    always_comb begin
        in_sign_a = op[0] & opa[WIDTH-1];
        in_sign_b = op[0] & opb[WIDTH-1];
        // The magnitude of the most negative value wraps to itself. Read as
        // unsigned, that is the correct magnitude.
        in_mag_a  = in_sign_a ? -opa : opa;
        in_mag_b  = in_sign_b ? -opb : opb;
    end

    // ------------------------------------------------------------------
    // One iteration step for each operation class
    // ------------------------------------------------------------------
    logic [W2-1:0]    mul_acc_nxt;
    logic [WIDTH-1:0] mplier_sh;
    logic             mul_last;
    logic [WIDTH:0]   rem_sh;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_diff;
    logic [W2-1:0]    div_acc_nxt;

    // NOTE: every signal driven in an always_comb gets a value on every path
    // (defaults first, or a full if/else). Otherwise synthesis infers a latch.
    always_comb begin
        mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;
        mplier_sh   = mplier >> 1;

        // The remainder shifted left by one needs WIDTH+1 bits. The old
        // remainder can be as large as divisor-1, so doubling it can carry
        // out of WIDTH bits.
        rem_sh    = acc[W2-1:WIDTH-1];
        no_borrow = (rem_sh >= {1'b0, mplier});
        // The difference is below the divisor, so it fits in WIDTH bits.
        rem_diff  = rem_sh[WIDTH-1:0] - mplier;
        if (no_borrow) begin
            div_acc_nxt = {rem_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Stop once this edge has consumed the last set multiplier bit. The
    // remaining iterations would only add zero.
    assign mul_last = (mplier_sh == '0) || (cnt == LAST);
`else
    assign mul_last = (cnt == LAST);
`endif

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] dz_hi;

    always_comb begin
        // sign_a and sign_b are latched as zero for unsigned ops, so these
        // conditions already cover the signedness.
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
        // Negating the magnitude again recovers the original opa bit pattern.
        dz_hi    = sign_a ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then samples pre-edge values, whatever order the statements
    // appear in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= 2'b00;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz_q        <= 1'b0;
            cnt         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            // done and div_by_zero are single-cycle qualifiers. FIX raises
            // them; every other edge clears them.
            done        <= 1'b0;
            div_by_zero <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q   <= op;
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        dz_q   <= op[1] && (opb == '0);
                        mcand  <= {{WIDTH{1'b0}}, in_mag_a};
                        mplier <= in_mag_b;
                        // A divide starts with the dividend in the quotient
                        // half. A multiply starts from a zero product.
                        acc    <= op[1] ? {{WIDTH{1'b0}}, in_mag_a} : '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end

                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (op_q[1]) begin
                            if (dz_q) begin
                                state <= FIX;
                            end else begin
                                acc <= div_acc_nxt;
                                if (cnt == LAST) begin
                                    state <= FIX;
                                end
                            end
                        end else begin
                            acc    <= mul_acc_nxt;
                            mcand  <= mcand << 1;
                            mplier <= mplier_sh;
                            if (mul_last) begin
                                state <= FIX;
                            end
                        end
                    end
                end

                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!op_q[1]) begin
                            hi <= prod_fix[W2-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (dz_q) begin
                            hi          <= dz_hi;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// tb_ex_muldiv_unit
// ----------------------------------------------------------------------------
// Directed self-checking bench for ex_muldiv_unit. Expected values are
// hand-computed constants. Latency is the number of falling edges, counted
// from the launch edge T0, up to and including the first one where done is
// seen. A result written at edge Tn therefore has latency n+1.
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int WIDTH = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 4;
`else
    localparam int EO_LAT = 34;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Presents a request that the next rising
    // edge (T0) samples.
    task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done within a bounded number of cycles. Returns at the
    // falling edge where done was seen, so the next launch is back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_lat, input logic [WIDTH-1:0] exp_hi,
                          input logic [WIDTH-1:0] exp_lo, input logic exp_dz);
        int lat;
        int busy_n;
        lat    = -1;
        busy_n = 0;
        launch(o, a, b);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dz));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int done_n;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;

        // Reset asserted asynchronously, before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset dz", 64'(div_by_zero), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("done pulse width", 64'(done), 64'(0));
        run_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu /0", 2'b10, 32'h1234_5678, 32'h0000_0000, 3, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        // Back-to-back: this launch happens on the edge right after FIX.
        run_op("div overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div neg /0", 2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 3, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        run_op("mult 6*-7", 2'b01, 32'd6, 32'hFFFF_FFF9, 34, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("multu early", 2'b00, 32'h0001_0000, 32'h0000_0003, EO_LAT, 32'h0000_0000, 32'h0003_0000, 1'b0);

        // Flush at T10 of DIVU 100/7. A start at T5 while busy is ignored.
        @(negedge clk);
        launch(2'b10, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) check("busy before flush", 64'(busy), 64'(1));
            start = (k == 5);
            op    = 2'b00;
            opa   = 32'd9;
            opb   = 32'd9;
            flush = (k == 10);
            @(posedge clk);
            #1;
            start = 1'b0;
            flush = 1'b0;
        end
        @(negedge clk);
        check("flush busy drop", 64'(busy), 64'(0));
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("flush no done", 64'(done_n), 64'(0));
        check("flush hi kept", 64'(hi), 64'(0));
        check("flush lo kept", 64'(lo), 64'(32'h0003_0000));

        // Flush and start on the same IDLE edge: no launch.
        op    = 2'b00;
        opa   = 32'd5;
        opb   = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush beats start", 64'(busy), 64'(0));

        // Reset pulsed mid-CALC clears the outputs asynchronously.
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'(0));
        check("mid reset lo", 64'(lo), 64'(0));
        check("mid reset hi", 64'(hi), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("after reset 6*7", 2'b00, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
